// File: rtl/ioctl_slot_loader.sv
// ioctl_slot_loader
// Routes each hps_io ioctl download to one of SLOTS memory regions chosen by
// ioctl_index, drops a SKIP-byte file header and writes the payload through a
// req/ack memory port, stalling hps_io with ioctl_wait while a write is open.
// Per-download byte count, mod-256 checksum and overflow are reported.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   ioctl_download/index/wr/
//   ioctl_addr/data            download stream from hps_io
//   ioctl_wait                 stall request back to hps_io
//   slot_base                  per-slot base address, slot k at [k*ADDR_W +: ADDR_W]
//   mem_addr/data/we, mem_ack  memory write request, held until acked
//   busy, done, done_slot      download status, done is a one-cycle pulse
//   byte_count, checksum,
//   overflow                   results of the current or last routed download
module ioctl_slot_loader #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned SLOTS  = 4,
  parameter int unsigned SKIP   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ioctl_download,
  input  logic [7:0]                ioctl_index,
  input  logic                      ioctl_wr,
  input  logic [24:0]               ioctl_addr,
  input  logic [7:0]                ioctl_data,
  output logic                      ioctl_wait,
  input  logic [SLOTS*ADDR_W-1:0]   slot_base,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [7:0]                mem_data,
  output logic                      mem_we,
  input  logic                      mem_ack,
  output logic                      busy,
  output logic                      done,
  output logic [3:0]                done_slot,
  output logic [ADDR_W:0]           byte_count,
  output logic [7:0]                checksum,
  output logic                      overflow
);

  typedef enum logic [1:0] {IDLE, RUN, WRITE, DRAIN} state_t;

  state_t              state;
  logic                dl_q;
  logic                fall_pend;
  logic [3:0]          slot_r;
  logic [ADDR_W-1:0]   base_r;

  logic                dl_rise;
  logic                dl_fall;
  logic                idx_ok;
  logic                hdr;
  logic                over;
  logic [31:0]         addr32;
  logic [31:0]         off32;
  logic [ADDR_W-1:0]   off_lo;
  logic [ADDR_W-1:0]   base_sel;

  always_comb begin
    dl_rise = ioctl_download & ~dl_q;
    dl_fall = ~ioctl_download & dl_q;
    addr32  = {7'd0, ioctl_addr};
    hdr     = addr32 < SKIP;
    off32   = addr32 - SKIP;
    // Any offset bit at or above ADDR_W means the payload no longer fits.
    over    = (off32 >> ADDR_W) != '0;
    off_lo  = off32[ADDR_W-1:0];
    idx_ok  = {24'd0, ioctl_index} < SLOTS;
    base_sel = '0;
    for (int unsigned k = 0; k < SLOTS; k++) begin
      if (ioctl_index == 8'(k)) base_sel = slot_base[k*ADDR_W +: ADDR_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      dl_q       <= 1'b0;
      fall_pend  <= 1'b0;
      slot_r     <= '0;
      base_r     <= '0;
      mem_we     <= 1'b0;
      ioctl_wait <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      byte_count <= '0;
      checksum   <= '0;
      done_slot  <= '0;
      mem_addr   <= '0;
      mem_data   <= '0;
    end else begin
      dl_q <= ioctl_download;
      done <= 1'b0;
      case (state)
        IDLE: begin
          // Out-of-range indices never leave IDLE, so the whole file is ignored.
          if (dl_rise && idx_ok) begin
            slot_r     <= ioctl_index[3:0];
            base_r     <= base_sel;
            byte_count <= '0;
            checksum   <= '0;
            overflow   <= 1'b0;
            fall_pend  <= 1'b0;
            busy       <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          if (ioctl_wr && !hdr && !over) begin
            mem_addr   <= base_r + off_lo;
            mem_data   <= ioctl_data;
            mem_we     <= 1'b1;
            ioctl_wait <= 1'b1;
            fall_pend  <= dl_fall;
            state      <= WRITE;
          end else begin
            if (ioctl_wr && !hdr) overflow <= 1'b1;
            if (dl_fall) state <= DRAIN;
          end
        end
        WRITE: begin
          // The download may end while the write is still open; remember it.
          if (dl_fall) fall_pend <= 1'b1;
          if (mem_we && mem_ack) begin
            mem_we     <= 1'b0;
            ioctl_wait <= 1'b0;
            byte_count <= byte_count + (ADDR_W+1)'(1);
            checksum   <= checksum + mem_data;
            state      <= (fall_pend || dl_fall) ? DRAIN : RUN;
          end
        end
        DRAIN: begin
          done      <= 1'b1;
          done_slot <= slot_r;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ioctl_slot_loader.sv
// Testbench for ioctl_slot_loader: two instances (16-bit/SKIP=16 and
// 8-bit/SKIP=0) share the byte stream; each has its own download line.
module tb_ioctl_slot_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        dl_a, dl_b;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;

  logic        wait_a, mem_we_a, busy_a, done_a, overflow_a, ack_a;
  logic [15:0] mem_addr_a;
  logic [7:0]  mem_data_a, checksum_a;
  logic [3:0]  done_slot_a;
  logic [16:0] byte_count_a;
  logic [63:0] slot_base_a = {16'h4000, 16'h0300, 16'h2000, 16'h1000};

  logic        wait_b, mem_we_b, busy_b, done_b, overflow_b, ack_b;
  logic [7:0]  mem_addr_b;
  logic [7:0]  mem_data_b, checksum_b;
  logic [3:0]  done_slot_b;
  logic [8:0]  byte_count_b;
  logic [31:0] slot_base_b = {8'h33, 8'h22, 8'hF0, 8'h11};

  ioctl_slot_loader #(.ADDR_W(16), .SLOTS(4), .SKIP(16)) u_dut_a (
    .clk(clk), .reset(reset), .ioctl_download(dl_a), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
    .ioctl_wait(wait_a), .slot_base(slot_base_a), .mem_addr(mem_addr_a),
    .mem_data(mem_data_a), .mem_we(mem_we_a), .mem_ack(ack_a), .busy(busy_a),
    .done(done_a), .done_slot(done_slot_a), .byte_count(byte_count_a),
    .checksum(checksum_a), .overflow(overflow_a)
  );

  ioctl_slot_loader #(.ADDR_W(8), .SLOTS(4), .SKIP(0)) u_dut_b (
    .clk(clk), .reset(reset), .ioctl_download(dl_b), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
    .ioctl_wait(wait_b), .slot_base(slot_base_b), .mem_addr(mem_addr_b),
    .mem_data(mem_data_b), .mem_we(mem_we_b), .mem_ack(ack_b), .busy(busy_b),
    .done(done_b), .done_slot(done_slot_b), .byte_count(byte_count_b),
    .checksum(checksum_b), .overflow(overflow_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  bit sel = 1'b0;
  int ack_delay = 0;
  logic ack = 1'b0;
  int wcnt = 0;
  int n_writes = 0;
  int last_ack_cyc = 0;
  int done_cnt_a = 0, done_cnt_b = 0;
  int busy_cyc_a = 0, we_cyc_a = 0, wait_cyc_a = 0;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;
  wr_t exp_q[$];

  assign ack_a = ack && !sel;
  assign ack_b = ack && sel;

  logic        cur_we, cur_wait, cur_busy, cur_done, cur_ovf;
  logic [15:0] cur_addr;
  logic [7:0]  cur_data, cur_cs;
  logic [3:0]  cur_slot;
  logic [16:0] cur_bc;

  always_comb begin
    cur_we   = sel ? mem_we_b : mem_we_a;
    cur_wait = sel ? wait_b : wait_a;
    cur_busy = sel ? busy_b : busy_a;
    cur_done = sel ? done_b : done_a;
    cur_ovf  = sel ? overflow_b : overflow_a;
    cur_addr = sel ? {8'd0, mem_addr_b} : mem_addr_a;
    cur_data = sel ? mem_data_b : mem_data_a;
    cur_cs   = sel ? checksum_b : checksum_a;
    cur_slot = sel ? done_slot_b : done_slot_a;
    cur_bc   = sel ? {8'd0, byte_count_b} : byte_count_a;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: acks after ack_delay cycles of mem_we and checks each
  // accepted write against the scoreboard.
  always @(negedge clk) begin
    if (cur_we && !reset) begin
      if (wcnt >= ack_delay) begin
        wr_t e;
        ack = 1'b1;
        wcnt = 0;
        last_ack_cyc = cyc;
        n_writes++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("wr_addr", {16'd0, cur_addr}, {16'd0, e.addr});
          chk("wr_data", {24'd0, cur_data}, {24'd0, e.data});
        end
      end else begin
        wcnt++;
        ack = 1'b0;
      end
    end else begin
      ack = 1'b0;
      wcnt = 0;
    end
  end

  always @(negedge clk) begin
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
    if (busy_a) busy_cyc_a++;
    if (mem_we_a) we_cyc_a++;
    if (wait_a) wait_cyc_a++;
  end

  // Called at a negedge; returns at the negedge where ioctl_wait is low again.
  task automatic send_byte(input bit b, input int a, input logic [7:0] dat,
                           input int exp_wait, input bit drop);
    int n = 0;
    ioctl_addr = 25'(a);
    ioctl_data = dat;
    ioctl_wr   = 1'b1;
    @(negedge clk);
    ioctl_wr = 1'b0;
    while (cur_wait && n < 50) begin
      if (drop && n == 0) begin
        if (b) dl_b = 1'b0; else dl_a = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    if (drop) begin
      if (b) dl_b = 1'b0; else dl_a = 1'b0;
    end
    chk("wait_cycles", n, exp_wait);
  endtask

  task automatic run_file(input bit b, input logic [7:0] idx, input int n, input int skip,
                          input int aw, input logic [15:0] base, input bit routed,
                          input bit drop_last);
    int d0;
    int bc = 0;
    logic [7:0] cs = 8'd0;
    bit ovf = 1'b0;
    int f = 0;
    int d = -1;
    logic [15:0] mask;
    mask = 16'((1 << aw) - 1);
    d0 = b ? done_cnt_b : done_cnt_a;
    @(negedge clk);
    sel = b;
    ioctl_index = idx;
    if (b) dl_b = 1'b1; else dl_a = 1'b1;
    @(negedge clk);
    chk("busy_rise", {31'd0, cur_busy}, {31'd0, routed});
    for (int i = 0; i < n; i++) begin
      bit st;
      logic [15:0] off;
      st = routed && i >= skip && (i - skip) < (1 << aw);
      if (routed && i >= skip && !st) ovf = 1'b1;
      if (st) begin
        off = 16'(i - skip);
        exp_q.push_back('{addr: (base + off) & mask, data: 8'(i)});
        bc++;
        cs += 8'(i);
      end
      send_byte(b, i, 8'(i), st ? ack_delay + 1 : 0, drop_last && i == n - 1);
    end
    if (!drop_last) begin
      f = cyc;
      if (b) dl_b = 1'b0; else dl_a = 1'b0;
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cur_done) begin
        d = cyc;
        break;
      end
    end
    if (routed) begin
      chk("done_latency", d - (drop_last ? last_ack_cyc : f), 2);
      chk("busy_fall", {31'd0, cur_busy}, 0);
    end
    repeat (3) @(negedge clk);
    chk("done_count", b ? done_cnt_b : done_cnt_a, d0 + (routed ? 1 : 0));
    if (routed) begin
      chk("byte_count", {15'd0, cur_bc}, bc);
      chk("checksum", {24'd0, cur_cs}, {24'd0, cs});
      chk("overflow", {31'd0, cur_ovf}, {31'd0, ovf});
      chk("done_slot", {28'd0, cur_slot}, {28'd0, idx[3:0]});
    end
    chk("sb_left", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int b0, we0, w0, d0, nw0, t;
    reset = 1'b1;
    dl_a = 1'b0;
    dl_b = 1'b0;
    ioctl_index = 8'd0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_we", {31'd0, mem_we_a}, 0);
    chk("rst_wait", {31'd0, wait_a}, 0);
    chk("rst_busy", {31'd0, busy_a}, 0);
    chk("rst_done", {31'd0, done_a}, 0);
    chk("rst_bc", {15'd0, byte_count_a}, 0);
    chk("rst_cs", {24'd0, checksum_a}, 0);
    chk("rst_ovf", {31'd0, overflow_a}, 0);
    chk("rst_slot", {28'd0, done_slot_a}, 0);
    chk("rst_addr", {16'd0, mem_addr_a}, 0);
    chk("rst_data", {24'd0, mem_data_a}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Slot 2, 16-byte header, ack immediately.
    ack_delay = 0;
    nw0 = n_writes;
    run_file(1'b0, 8'd2, 20, 16, 16, 16'h0300, 1'b1, 1'b0);
    chk("n_writes_t1", n_writes - nw0, 4);

    // Same file with a slow memory.
    ack_delay = 5;
    nw0 = n_writes;
    run_file(1'b0, 8'd2, 20, 16, 16, 16'h0300, 1'b1, 1'b0);
    chk("n_writes_t2", n_writes - nw0, 4);
    ack_delay = 0;

    // Unroutable index: nothing happens, previous results stay.
    b0 = busy_cyc_a; we0 = we_cyc_a; w0 = wait_cyc_a; nw0 = n_writes;
    run_file(1'b0, 8'd7, 20, 16, 16, 16'h0000, 1'b0, 1'b0);
    chk("idx7_busy", busy_cyc_a - b0, 0);
    chk("idx7_we", we_cyc_a - we0, 0);
    chk("idx7_wait", wait_cyc_a - w0, 0);
    chk("idx7_writes", n_writes - nw0, 0);
    chk("idx7_bc", {15'd0, byte_count_a}, 4);
    chk("idx7_cs", {24'd0, checksum_a}, 32'h46);
    chk("idx7_slot", {28'd0, done_slot_a}, 2);

    // 8-bit address space: wrap and overflow.
    nw0 = n_writes;
    run_file(1'b1, 8'd1, 258, 0, 8, 16'h00F0, 1'b1, 1'b0);
    chk("n_writes_t4", n_writes - nw0, 256);

    // Download falls while the last write waits for its ack.
    ack_delay = 3;
    run_file(1'b0, 8'd3, 17, 16, 16, 16'h4000, 1'b1, 1'b1);

    // Reset in the middle of a write that is never acked.
    ack_delay = 1000;
    nw0 = n_writes;
    @(negedge clk);
    sel = 1'b0;
    ioctl_index = 8'd0;
    dl_a = 1'b1;
    @(negedge clk);
    ioctl_addr = 25'd16;
    ioctl_data = 8'hA5;
    ioctl_wr = 1'b1;
    @(negedge clk);
    ioctl_wr = 1'b0;
    chk("pre_rst_we", {31'd0, mem_we_a}, 1);
    d0 = done_cnt_a;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_we", {31'd0, mem_we_a}, 0);
    chk("mid_rst_wait", {31'd0, wait_a}, 0);
    chk("mid_rst_busy", {31'd0, busy_a}, 0);
    chk("mid_rst_done", {31'd0, done_a}, 0);
    chk("mid_rst_bc", {15'd0, byte_count_a}, 0);
    chk("mid_rst_cs", {24'd0, checksum_a}, 0);
    chk("mid_rst_ovf", {31'd0, overflow_a}, 0);
    chk("mid_rst_slot", {28'd0, done_slot_a}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    // Download still high when reset releases: routed straight away.
    chk("post_rst_busy", {31'd0, busy_a}, 1);
    chk("post_rst_no_done", done_cnt_a, d0);
    ack_delay = 0;
    dl_a = 1'b0;
    t = 0;
    while (!done_a && t < 20) begin
      t++;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk("post_rst_done", done_cnt_a, d0 + 1);
    chk("post_rst_bc", {15'd0, byte_count_a}, 0);
    chk("post_rst_writes", n_writes - nw0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
